// File: rtl/seq_encoder.sv
// ----------------------------------------------------------------------------
// seq_encoder
//
// Sequential 8-to-3 encoder and bitmap serializer. An 8-bit bitmap in the
// decoder's one-hot/multi-hot "y" format is accepted on a valid/ready input
// handshake. The 3-bit index of every set bit is then emitted, lowest bit
// first, one index per output handshake.
//
// Optional feature macro: SEQ_ENC_ONEHOT_CHECK_EN
//   defined   : a multi-hot bitmap sets the sticky err flag and is dropped
//               without emitting any beats (cnt still records its popcount).
//   undefined : err is tied to 0 and multi-hot bitmaps are serialized.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   y_in       in   [N-1:0] bitmap to encode
//   in_valid   in   y_in is valid
//   in_ready   out  block can accept a bitmap (IDLE)
//   a_out      out  [CW-1:0] index of lowest pending bit (0 when not valid)
//   out_valid  out  a_out is valid (BUSY)
//   out_ready  in   downstream accepts a_out
//   out_last   out  current beat is the final beat of this bitmap
//   cnt        out  [CW:0] popcount of the last accepted bitmap
//   err        out  sticky multi-hot error flag
// ----------------------------------------------------------------------------
module seq_encoder #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  y_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [CW-1:0] a_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [CW:0]   cnt,
    output logic          err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CW:0]  CNT_ONE  = {{CW{1'b0}}, 1'b1};
    localparam logic [N-1:0] PEND_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] PEND_ZERO = {N{1'b0}};

    // Number of set bits in a bitmap.
    function automatic logic [CW:0] popcount(input logic [N-1:0] v);
        logic [CW:0] c;
        c = {(CW+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + {{CW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Index of the lowest set bit; 0 for an empty bitmap.
    function automatic logic [CW-1:0] lowest_index(input logic [N-1:0] v);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        // Scan downwards so the lowest set bit is the last one to win.
        for (int i = N - 1; i >= 0; i--) begin
            idx = v[i] ? CW'(i) : idx;
        end
        return idx;
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic [N-1:0]  pend_r;
    logic [CW:0]   cnt_r;
    logic          accept_s;
    logic          xfer_s;
    logic          drop_s;
    logic [CW:0]   in_pop_s;

    assign in_pop_s = popcount(y_in);
    assign accept_s = in_valid & in_ready;
    assign xfer_s   = out_valid & out_ready;

`ifdef SEQ_ENC_ONEHOT_CHECK_EN
    logic err_r;

    // Multi-hot bitmaps are rejected when the one-hot check is enabled.
    assign drop_s = (in_pop_s > CNT_ONE);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (accept_s && drop_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign drop_s = 1'b0;
    assign err    = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                // A zero or dropped bitmap leaves the FSM in IDLE.
                if (accept_s && (y_in != PEND_ZERO) && !drop_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (xfer_s && out_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from the state and pending-bit registers only.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_last  = 1'b0;
        a_out     = {CW{1'b0}};
        case (state_r)
            IDLE: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                out_last  = 1'b0;
                a_out     = {CW{1'b0}};
            end
            BUSY: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                out_last  = (popcount(pend_r) == CNT_ONE);
                a_out     = lowest_index(pend_r);
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                out_last  = 1'b0;
                a_out     = {CW{1'b0}};
            end
        endcase
    end

    // Pending-bit and popcount registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= PEND_ZERO;
            cnt_r  <= {(CW+1){1'b0}};
        end else if (accept_s) begin
            pend_r <= drop_s ? PEND_ZERO : y_in;
            cnt_r  <= in_pop_s;
        end else if (xfer_s) begin
            // v & (v - 1) clears exactly the lowest set bit.
            pend_r <= pend_r & (pend_r - PEND_ONE);
            cnt_r  <= cnt_r;
        end else begin
            pend_r <= pend_r;
            cnt_r  <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: tb/tb_seq_encoder.sv
// ----------------------------------------------------------------------------
// tb_seq_encoder
//
// Directed plus randomized bench for seq_encoder. The reference model turns
// each bitmap into a queue of expected codes (the set bit positions in
// ascending order) and pops the queue whenever a beat is handed to a ready
// downstream.
// ----------------------------------------------------------------------------
module tb_seq_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] y_in;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] a_out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [3:0] cnt;
    logic       err;

    int tests = 0;
    int fails = 0;
    logic exp_err = 1'b0;

    seq_encoder #(.N(8), .CW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .y_in     (y_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_out    (a_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .cnt      (cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load one bitmap and follow its beats. stall: initial cycles with
    // out_ready low; rnd: random out_ready afterwards; abort_after: stop
    // following after this many transfers (-1 = run to completion).
    task automatic run_bitmap(input logic [7:0] bm, input int stall, input bit rnd,
                              input int abort_after);
        int   q[$];
        int   pops;
        int   cyc;
        logic [3:0] ec;
        @(negedge clk);
        chk("in_ready_before_load", {31'd0, in_ready}, 32'd1);
        y_in     = bm;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        y_in     = 8'($urandom);
        ec = 4'($countones(bm));
        for (int i = 0; i < 8; i++) begin
            if (bm[i]) q.push_back(i);
        end
`ifdef SEQ_ENC_ONEHOT_CHECK_EN
        if (ec > 4'd1) begin
            exp_err = 1'b1;
            q.delete();
        end
`endif
        chk("cnt", {28'd0, cnt}, {28'd0, ec});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        pops = 0;
        cyc  = 0;
        while (q.size() > 0) begin
            if (abort_after >= 0 && pops == abort_after) return;
            if (cyc > 200) begin
                tests++;
                fails++;
                $error("FAIL timeout: observed %0d beats pending expected 0", q.size());
                return;
            end
            chk("out_valid_busy", {31'd0, out_valid}, 32'd1);
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            chk("a_out", {29'd0, a_out}, q[0]);
            chk("out_last", {31'd0, out_last}, (q.size() == 1) ? 32'd1 : 32'd0);
            out_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            // Input presented while BUSY must be ignored.
            in_valid = 1'($urandom_range(0, 1));
            y_in     = 8'($urandom);
            @(posedge clk);
            if (out_ready) begin
                void'(q.pop_front());
                pops++;
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            cyc++;
        end
        chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        chk("a_out_idle", {29'd0, a_out}, 32'd0);
        chk("out_last_idle", {31'd0, out_last}, 32'd0);
        chk("cnt_hold", {28'd0, cnt}, {28'd0, ec});
    endtask

    initial begin
        rst       = 1'b0;
        y_in      = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_a_out", {29'd0, a_out}, 32'd0);
        chk("rst_cnt", {28'd0, cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // One-hot sweep.
        for (int i = 0; i < 8; i++) begin
            run_bitmap(8'(1 << i), 0, 1'b0, -1);
        end
        // Multi-hot with full throughput.
        run_bitmap(8'hA5, 0, 1'b0, -1);
        // Backpressure for 5 cycles.
        run_bitmap(8'h18, 5, 1'b0, -1);
        // Zero bitmap, then a busy bitmap with ignored input pulses.
        run_bitmap(8'h00, 0, 1'b0, -1);
        run_bitmap(8'h0F, 0, 1'b0, -1);
        run_bitmap(8'hFF, 0, 1'b0, -1);

        // Asynchronous reset mid-bitmap.
        run_bitmap(8'hFF, 0, 1'b0, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_cnt", {28'd0, cnt}, 32'd0);
        chk("midrst_a_out", {29'd0, a_out}, 32'd0);
        chk("midrst_out_last", {31'd0, out_last}, 32'd0);
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_bitmap(8'h40, 0, 1'b0, -1);

`ifdef SEQ_ENC_ONEHOT_CHECK_EN
        run_bitmap(8'h06, 0, 1'b0, -1);
        run_bitmap(8'h04, 0, 1'b0, -1);
        chk("err_sticky", {31'd0, err}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_err = 1'b0;
        chk("err_cleared", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
`endif

        // Randomized bitmaps with random backpressure.
        for (int n = 0; n < 40; n++) begin
            run_bitmap(8'($urandom), int'($urandom_range(0, 3)), 1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
